// File: rtl/pio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pio_pkg
//  Description : Shared constants for the Avalon-MM GPIO block. These are the
//                register word addresses and the codes that select the edge
//                type and the IRQ type.
//  Revision    : 1.0 - initial release
// ============================================================================
package pio_pkg;

  // Register word addresses
  localparam logic [2:0] REG_DATA     = 3'd0;
  localparam logic [2:0] REG_DIR      = 3'd1;
  localparam logic [2:0] REG_MASK     = 3'd2;
  localparam logic [2:0] REG_EDGE     = 3'd3;
  localparam logic [2:0] REG_OUTSET   = 3'd4;
  localparam logic [2:0] REG_OUTCLEAR = 3'd5;

  // Edge selection codes
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Interrupt source selection codes
  localparam int IRQ_LEVEL = 0;
  localparam int IRQ_EDGE  = 1;

endpackage
`default_nettype wire

// File: rtl/pio_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module      : pio_edge_sync
//  Description : Synchroniser chain for asynchronous GPIO inputs. It also holds
//                a one-cycle history register and the edge selection logic.
//                After reset, a prime counter holds edge detection off until
//                both the chain and the history register contain real samples.
//  Revision    : 1.0 - initial release
// ============================================================================
module pio_edge_sync
  import pio_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] i_in_port,
  output logic [DATA_WIDTH-1:0] o_in_sync,
  output logic [DATA_WIDTH-1:0] o_edge
);

  localparam logic [2:0] c_PRIME_MAX = 3'(SYNC_STAGES + 1);

  logic [DATA_WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] r_prev;
  logic [2:0]            r_prime_cnt;
  logic                  w_primed;
  logic [DATA_WIDTH-1:0] w_rise;
  logic [DATA_WIDTH-1:0] w_fall;
  logic [DATA_WIDTH-1:0] w_edge_raw;

  // Shift the input through the synchroniser. Keep the last synchronised value as history.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_prev <= '0;
    end else begin
      r_sync[0] <= i_in_port;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  // Count cycles since reset and saturate once the chain and history hold valid samples.
  always_ff @(posedge clk) begin
    if (!reset_n)                    r_prime_cnt <= '0;
    else if (r_prime_cnt != c_PRIME_MAX) r_prime_cnt <= r_prime_cnt + 3'd1;
  end

  assign w_primed  = (r_prime_cnt == c_PRIME_MAX);
  assign o_in_sync = r_sync[SYNC_STAGES-1];
  assign w_rise    =  o_in_sync & ~r_prev;
  assign w_fall    = ~o_in_sync &  r_prev;

  generate
    if (EDGE_TYPE == EDGE_RISE) begin : g_edge_rise
      assign w_edge_raw = w_rise;
    end else if (EDGE_TYPE == EDGE_FALL) begin : g_edge_fall
      assign w_edge_raw = w_fall;
    end else if (EDGE_TYPE == EDGE_ANY) begin : g_edge_any
      assign w_edge_raw = w_rise | w_fall;
    end else begin : g_edge_none
      assign w_edge_raw = '0;
    end
  endgenerate

  assign o_edge = w_primed ? w_edge_raw : '0;

endmodule
`default_nettype wire

// File: rtl/avalon_pio_gpio.sv
`default_nettype none
// ============================================================================
//  Module      : avalon_pio_gpio
//  Description : Parametrised Avalon-MM slave GPIO block. It provides per-bit
//                direction control, synchronised inputs, sticky edge capture
//                with write-1-to-clear, and a registered maskable interrupt.
//                Optional macro PIO_BITSETCLR_EN adds two write-only registers,
//                OUTSET (address 4) and OUTCLEAR (address 5), for atomic bit
//                set and clear on the output data.
//  Revision    : 1.0 - initial release
// ============================================================================
module avalon_pio_gpio
  import pio_pkg::*;
#(
  parameter int          DATA_WIDTH  = 32,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int          SYNC_STAGES = 2,
  parameter int          EDGE_TYPE   = EDGE_RISE,
  parameter int          IRQ_TYPE    = IRQ_EDGE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0] oe_port,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] r_data_out;
  logic [DATA_WIDTH-1:0] r_dir;
  logic [DATA_WIDTH-1:0] r_mask;
  logic [DATA_WIDTH-1:0] r_edge_cap;
  logic                  r_irq;
  logic [DATA_WIDTH-1:0] w_in_sync;
  logic [DATA_WIDTH-1:0] w_edge;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_irq_src;
  logic                  w_wr;

  assign w_wr    = chipselect & ~write_n;
  assign w_wdata = writedata[DATA_WIDTH-1:0];

  pio_edge_sync #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_edge_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_in_port (in_port),
    .o_in_sync (w_in_sync),
    .o_edge    (w_edge)
  );

  // Output data register: whole-word writes, plus atomic set/clear when enabled.
  always_ff @(posedge clk) begin
    if (!reset_n)                                   r_data_out <= RESET_VALUE[DATA_WIDTH-1:0];
    else if (w_wr && address == REG_DATA)           r_data_out <= w_wdata;
`ifdef PIO_BITSETCLR_EN
    else if (w_wr && address == REG_OUTSET)         r_data_out <= r_data_out | w_wdata;
    else if (w_wr && address == REG_OUTCLEAR)       r_data_out <= r_data_out & ~w_wdata;
`endif
  end

  // Direction and interrupt mask registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_dir  <= '0;
      r_mask <= '0;
    end else begin
      if (w_wr && address == REG_DIR)  r_dir  <= w_wdata;
      if (w_wr && address == REG_MASK) r_mask <= w_wdata;
    end
  end

  // Sticky edge capture. A new edge in the same cycle as a write-1-to-clear keeps the bit set.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_edge_cap <= '0;
    end else if (w_wr && address == REG_EDGE) begin
      r_edge_cap <= (r_edge_cap & ~w_wdata) | w_edge;
    end else begin
      r_edge_cap <= r_edge_cap | w_edge;
    end
  end

  generate
    if (IRQ_TYPE == IRQ_LEVEL) begin : g_irq_level
      assign w_irq_src = w_in_sync & r_mask;
    end else if (IRQ_TYPE == IRQ_EDGE) begin : g_irq_edge
      assign w_irq_src = r_edge_cap & r_mask;
    end else begin : g_irq_off
      assign w_irq_src = '0;
    end
  endgenerate

  // Registered interrupt request.
  always_ff @(posedge clk) begin
    if (!reset_n) r_irq <= 1'b0;
    else          r_irq <= |w_irq_src;
  end

  // Zero-wait-state read mux. Bits above DATA_WIDTH read as zero.
  always_comb begin
    readdata = '0;
    case (address)
      REG_DATA:     readdata[DATA_WIDTH-1:0] = (r_dir & r_data_out) | (~r_dir & w_in_sync);
      REG_DIR:      readdata[DATA_WIDTH-1:0] = r_dir;
      REG_MASK:     readdata[DATA_WIDTH-1:0] = r_mask;
      REG_EDGE:     readdata[DATA_WIDTH-1:0] = r_edge_cap;
      REG_OUTSET,
      REG_OUTCLEAR: readdata = '0;
      default:      readdata = '0;
    endcase
  end

  assign out_port = r_data_out;
  assign oe_port  = r_dir;
  assign irq      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_avalon_pio_gpio.sv
`default_nettype none
// ============================================================================
//  Module      : tb_avalon_pio_gpio
//  Description : Directed self-checking bench for avalon_pio_gpio. Settings:
//                RESET_VALUE=A5, 2 sync stages, rising edge, edge IRQ.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_avalon_pio_gpio;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] in_port;
  logic [31:0] out_port;
  logic [31:0] oe_port;
  logic        irq;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  avalon_pio_gpio #(
    .DATA_WIDTH  (32),
    .RESET_VALUE (32'hA5),
    .SYNC_STAGES (2),
    .EDGE_TYPE   (0),
    .IRQ_TYPE    (1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .out_port   (out_port),
    .oe_port    (oe_port),
    .irq        (irq)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // One-cycle bus write. Returns 1 time unit after the write edge.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic read_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check_value(tag, readdata, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = '0;
    repeat (3) @(posedge clk);
    #1;
    check_value("reset_out_port", out_port, 32'hA5);
    check_value("reset_oe_port", oe_port, 32'h0);
    check_value("reset_irq", {31'b0, irq}, 32'h0);
    read_check("reset_edge_rd", 3'd3, 32'h0);
    read_check("reset_dir_rd", 3'd1, 32'h0);
    read_check("reset_mask_rd", 3'd2, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    next_cycle();

    // Direction, output data, and mixed DATA readback
    bus_write(3'd1, 32'h0000_00FF);
    bus_write(3'd0, 32'h1234_5678);
    check_value("oe_port_dir", oe_port, 32'h0000_00FF);
    check_value("out_port_data", out_port, 32'h1234_5678);
    read_check("data_rd_mixed", 3'd0, 32'h0000_0078);
    read_check("dir_rd", 3'd1, 32'h0000_00FF);
    read_check("reserved_rd4", 3'd4, 32'h0);

    // Rising edge on bit 3: in_port changes just after edge k and is captured at k+3
    next_cycle();
    in_port = 32'h8;
    next_cycle();
    read_check("edge_k1", 3'd3, 32'h0);
    next_cycle();
    read_check("edge_k2", 3'd3, 32'h0);
    next_cycle();
    read_check("edge_k3", 3'd3, 32'h8);
    check_value("irq_masked_off", {31'b0, irq}, 32'h0);
    next_cycle();
    check_value("irq_masked_off2", {31'b0, irq}, 32'h0);

    // Enable mask: irq asserts one cycle after the mask write
    bus_write(3'd2, 32'h8);
    check_value("irq_mask_edge", {31'b0, irq}, 32'h0);
    next_cycle();
    check_value("irq_mask_next", {31'b0, irq}, 32'h1);

    // Write-1-to-clear: capture clears at the write edge, irq drops one cycle later
    bus_write(3'd3, 32'h8);
    read_check("edge_w1c", 3'd3, 32'h0);
    check_value("irq_w1c_edge", {31'b0, irq}, 32'h1);
    next_cycle();
    check_value("irq_w1c_next", {31'b0, irq}, 32'h0);

    // A falling edge is ignored with rising-edge selection
    in_port = 32'h0;
    repeat (4) next_cycle();
    read_check("fall_ignored", 3'd3, 32'h0);
    check_value("irq_fall_ignored", {31'b0, irq}, 32'h0);

    // W1C in the same cycle a new rising edge is captured: the set wins
    in_port = 32'h8;
    next_cycle();
    next_cycle();
    bus_write(3'd3, 32'h8);
    read_check("set_wins", 3'd3, 32'h8);
    next_cycle();
    read_check("set_wins_hold", 3'd3, 32'h8);
    check_value("irq_set_wins", {31'b0, irq}, 32'h1);

    // Mid-operation reset with inputs held high, then released: prime gating
    @(negedge clk);
    in_port = 32'hFFFF_FFFF;
    reset_n = 1'b0;
    repeat (2) next_cycle();
    check_value("mid_reset_out", out_port, 32'hA5);
    check_value("mid_reset_irq", {31'b0, irq}, 32'h0);
    read_check("mid_reset_mask", 3'd2, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) next_cycle();
    read_check("prime_no_edge", 3'd3, 32'h0);
    read_check("prime_in_sync", 3'd0, 32'hFFFF_FFFF);
    check_value("prime_oe", oe_port, 32'h0);

`ifdef PIO_BITSETCLR_EN
    bus_write(3'd0, 32'h0000_00F0);
    bus_write(3'd4, 32'h0000_000F);
    check_value("outset", out_port, 32'h0000_00FF);
    bus_write(3'd5, 32'h0000_0081);
    check_value("outclear", out_port, 32'h0000_007E);
    read_check("outset_rd", 3'd4, 32'h0);
    read_check("outclear_rd", 3'd5, 32'h0);
`else
    bus_write(3'd0, 32'h0000_00F0);
    bus_write(3'd4, 32'h0000_000F);
    check_value("reserved_wr4", out_port, 32'h0000_00F0);
    bus_write(3'd5, 32'h0000_0081);
    check_value("reserved_wr5", out_port, 32'h0000_00F0);
    read_check("reserved_rd5", 3'd5, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
